data_memory_lsu: RTL
====================

Name: data_memory_lsu

Overview:
- Parametrised successor to the single-cycle data memory, for the pipelined core's MEM stage.
- Byte-addressed memory with RISC-V load/store sizes: byte-lane writes and sign/zero-extended sub-word loads.
- Request/response valid-ready handshake, one transaction outstanding.
- Configurable wait states to model slower memory.

Parameters:
DATA_WIDTH, 32, word width in bits; legal values 32 or 64.
DMEM_DEPTH_WORDS, 1024, number of words; power of two.
WAIT_STATES, 0, extra cycles before a response is presented; range 0..15.
(derived) BYTES = DATA_WIDTH/8; OFS_W = clog2(BYTES); ADDR_WIDTH = clog2(DMEM_DEPTH_WORDS) + OFS_W.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  reset, asynchronous assert, active-high.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_we  in  1  1 = store, 0 = load.
req_addr  in  ADDR_WIDTH  byte address.
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (only when DATA_WIDTH = 64).
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
req_wdata  in  DATA_WIDTH  store data, right-aligned.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response.
rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and for errors.
rsp_err  out  1  misaligned access or illegal size.

Behaviour:
- Reset, asynchronous: FSM to IDLE, wait counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0. The memory array is never reset.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = 1 only in IDLE.
  - rsp_valid = 1 only in RESP.
- Acceptance is at the edge where req_valid and req_ready are both 1 in IDLE.
  - The request is decoded at this edge.
  - The transition is to RESP if WAIT_STATES = 0, otherwise to WAIT with the counter loaded with WAIT_STATES-1.
- WAIT: the counter decrements each cycle; when it reaches 0, the next state is RESP.
- Latency: rsp_valid asserts WAIT_STATES+1 cycles after the acceptance edge.
- RESP holds rsp_valid, rsp_rdata and rsp_err stable until rsp_ready = 1. The FSM then goes to IDLE, and req_ready rises in the following cycle. There is no same-cycle response and new request.
- Error: size 3 with DATA_WIDTH = 32 is illegal. A request is misaligned when req_addr is not a multiple of 2^req_size. On error:
  - no write occurs;
  - rsp_err = 1 and rsp_rdata = 0;
  - latency is unchanged.
- Lane select:
  - word index = req_addr[ADDR_WIDTH-1:OFS_W];
  - byte offset = req_addr[OFS_W-1:0].
- Store: commits to the array at the acceptance edge.
  - Only the 2^req_size bytes starting at the offset are written, taken from req_wdata[8*2^size-1:0].
  - All other bytes are unchanged.
  - The response has rsp_rdata = 0 and rsp_err = 0.
- Load: the word is read at the acceptance edge.
  - The selected bytes are shifted to bit 0 and sign- or zero-extended to DATA_WIDTH.
  - The result is registered into rsp_rdata.
  - A full-width load ignores req_unsigned.
- Ordering: a load issued after a store's response returns the stored data, since there is one outstanding transaction.
- Reset mid-transaction:
  - a store already accepted remains committed;
  - a pending response is dropped;
  - the FSM returns to IDLE.
- req_* inputs are ignored outside IDLE.

Test Plan:
1. DATA_WIDTH=32, WAIT_STATES=0. Store word 0xDEADBEEF at 0x10. Then load byte signed at 0x11 -> 0xFFFFFFBE; byte unsigned at 0x11 -> 0x000000BE; half signed at 0x12 -> 0xFFFFDEAD; word at 0x10 -> 0xDEADBEEF. Each rsp_valid comes 1 cycle after acceptance.
2. Store byte 0x12 at 0x13, then load word at 0x10 -> 0x12ADBEEF. Store half 0x8001 at 0x10, then load word -> 0x12AD8001; load half unsigned at 0x10 -> 0x00008001.
3. Load word at 0x2 and store half at 0x5 -> both give rsp_err=1 and rsp_rdata=0. A subsequent word load at 0x4 returns the previous contents unchanged.
4. WAIT_STATES=3. Accept a load -> rsp_valid rises exactly 4 cycles after acceptance, and req_ready stays 0 throughout. Holding rsp_ready=0 for 5 more cycles -> rsp_valid, rsp_rdata and rsp_err stay stable. Raise rsp_ready -> IDLE, with req_ready=1 one cycle later.
5. WAIT_STATES=3. Accept a store of 0xCAFEF00D at 0x20, then assert rst in WAIT -> rsp_valid=0, req_ready=1 after reset release. A word load at 0x20 returns 0xCAFEF00D.
6. DATA_WIDTH=64. Store dword 0x0123456789ABCDEF at 0x8, then load word signed at 0xC -> 0x0000000001234567; load word signed at 0x8 -> 0xFFFFFFFF89ABCDEF. Dword load at 0xC -> rsp_err=1.

Source files
------------

// File: rtl/data_memory_lsu.sv
// Byte-addressed data memory for the MEM stage.
// Supports RISC-V byte/half/word/dword accesses through a valid-ready request/response
// handshake with one outstanding transaction and optional wait states.
module data_memory_lsu #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned DMEM_DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES      = 0,
    localparam int unsigned BYTES           = DATA_WIDTH / 8,
    localparam int unsigned OFS_W           = $clog2(BYTES),
    localparam int unsigned ADDR_WIDTH      = $clog2(DMEM_DEPTH_WORDS) + OFS_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned WORD_W = ADDR_WIDTH - OFS_W;
    // Counter preload so that WAIT is occupied for exactly WAIT_STATES cycles.
    localparam logic [3:0] WaitLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [DATA_WIDTH-1:0] mem [DMEM_DEPTH_WORDS];

    logic [WORD_W-1:0]     word_idx;
    logic [OFS_W-1:0]      byte_ofs;
    logic [2:0]            ofs3;
    logic [2:0]            align_mask;
    logic                  size_illegal;
    logic                  misaligned;
    logic                  access_err;
    logic [BYTES-1:0]      be;
    logic [DATA_WIDTH-1:0] wdata_shift;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_ext;
    logic                  sign_bit;
    logic                  accept;
    logic                  wr_en;
    int                    nbytes;
    int                    nbits;

    assign word_idx = req_addr[ADDR_WIDTH-1:OFS_W];
    assign byte_ofs = req_addr[OFS_W-1:0];
    assign rd_word  = mem[word_idx];

    // Decode size/alignment errors and build the store byte-enable and lane-aligned data.
    always_comb begin
        ofs3         = 3'(byte_ofs);
        align_mask   = 3'((4'd1 << req_size) - 4'd1);
        size_illegal = (req_size == 2'd3) && (DATA_WIDTH == 32);
        misaligned   = |(ofs3 & align_mask);
        access_err   = size_illegal || misaligned;
        nbytes       = 1 << req_size;
        nbits        = 8 << req_size;
        be           = '0;
        for (int b = 0; b < int'(BYTES); b++) begin
            be[b] = (b >= int'(byte_ofs)) && (b < int'(byte_ofs) + nbytes);
        end
        wdata_shift = req_wdata << {byte_ofs, 3'b000};
    end

    // Align the addressed bytes to bit 0 and sign/zero-extend above the access size.
    always_comb begin
        shifted  = rd_word >> {byte_ofs, 3'b000};
        sign_bit = 1'b0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            if (i == nbits - 1) sign_bit = shifted[i];
        end
        load_ext = shifted;
        // Full-width loads never enter this loop, so req_unsigned has no effect on them.
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            if (i >= nbits) load_ext[i] = sign_bit & ~req_unsigned;
        end
    end

    // Handshake FSM: next state, wait counter, and response capture at acceptance.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        accept      = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept      = 1'b1;
                    rsp_err_d   = access_err;
                    rsp_rdata_d = (req_we || access_err) ? '0 : load_ext;
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitLoad;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) state_d = StResp;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign wr_en     = accept && req_we && !access_err;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Control and response registers; reset drops any pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Byte-lane store into the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= wdata_shift[8*b +: 8];
            end
        end
    end

endmodule
